// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: opcodes, FSM states,
// PC-source and ALU-operation selects.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned IR_W  = 16;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_LW  = 4'h4;
  localparam logic [OP_W-1:0] OP_SW  = 4'h5;
  localparam logic [OP_W-1:0] OP_BEQ = 4'h6;
  localparam logic [OP_W-1:0] OP_JMP = 4'h7;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [SEL_W-1:0] PC_SRC_INC    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
  localparam logic [SEL_W-1:0] ALU_OR  = 2'b11;

  // Loads and stores share the address-generation path through the ALU.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-response watchdog: counts cycles a request waits without ready and
// flags expiry on the TIMEOUT-th pending cycle unless ready arrives with it.
module ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic pending,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (pending && !ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A ready arriving in the expiry cycle wins over the timeout.
  assign expire = pending && !ready && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mc_controller.sv
// Multicycle control FSM for the 16-bit CPU: sequences fetch/decode/execute/
// memory/write-back, owns memory handshakes, halt detection and retire count.
module cpu_mc_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [IR_W-1:0]    instr,
  input  logic [PC_W-1:0]    pc,
  input  logic               zero_flag,
  output logic               imem_req,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               ir_load,
  output logic               pc_write,
  output logic [SEL_W-1:0]   pc_src,
  output logic [SEL_W-1:0]   alu_op,
  output logic               alu_src_imm,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               halted,
  output logic               timeout_err,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [ST_W-1:0]    state_dbg
);

  state_t            state, next_state;
  logic [IR_W-1:0]   ir;
  logic [PC_W-1:0]   fetch_pc;
  logic [OP_W-1:0]   opcode;
  logic              retire_c;
  logic              set_illegal_c;
  logic              set_timeout_c;
  logic              wd_pending_c;
  logic              wd_ready_c;
  logic              wd_clear_c;
  logic              wd_expire_c;

  assign opcode    = ir[IR_W-1:IR_W-OP_W];
  assign state_dbg = ST_W'(state);

  assign wd_pending_c = (state == FETCH) || (state == MEM);
  assign wd_ready_c   = (state == FETCH) ? imem_ready : dmem_ready;
  assign wd_clear_c   = (next_state != state);

  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear_c),
    .pending (wd_pending_c),
    .ready   (wd_ready_c),
    .expire  (wd_expire_c)
  );

  // State register plus the IR copy, fetch PC, sticky flags and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      fetch_pc    <= '0;
      retired     <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH && imem_ready) begin
        ir       <= instr;
        fetch_pc <= pc;
      end
      if (retire_c && (retired != '1)) begin
        retired <= retired + CNT_W'(1);
      end
      if (next_state == HALT && state != HALT) begin
        halted <= 1'b1;
      end
      if (set_timeout_c) begin
        timeout_err <= 1'b1;
      end
      if (set_illegal_c) begin
        illegal_op <= 1'b1;
      end
    end
  end

  // Next-state and Moore/ready-gated strobe decode.
  always_comb begin
    next_state    = state;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_INC;
    alu_op        = ALU_ADD;
    alu_src_imm   = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 1'b0;
    retire_c      = 1'b0;
    set_illegal_c = 1'b0;
    set_timeout_c = 1'b0;

    unique case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_INC;
          next_state = DECODE;
        end else if (wd_expire_c) begin
          set_timeout_c = 1'b1;
          next_state    = HALT;
        end
      end
      DECODE: begin
        if (opcode[OP_W-1]) begin
          set_illegal_c = 1'b1;
          retire_c      = 1'b1;
          next_state    = FETCH;
        end else if (opcode == OP_JMP) begin
          retire_c = 1'b1;
          if (ir[PC_W-1:0] == fetch_pc) begin
            next_state = HALT;
          end else begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            next_state = FETCH;
          end
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_mem_op(opcode)) begin
          alu_src_imm = 1'b1;
          alu_op      = ALU_ADD;
          next_state  = MEM;
        end else if (opcode == OP_BEQ) begin
          alu_op   = ALU_SUB;
          retire_c = 1'b1;
          if (zero_flag) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BRANCH;
          end
          next_state = FETCH;
        end else begin
          alu_op     = opcode[SEL_W-1:0];
          next_state = WB;
        end
      end
      MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (opcode == OP_SW);
        alu_src_imm = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            retire_c   = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (wd_expire_c) begin
          set_timeout_c = 1'b1;
          next_state    = HALT;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LW);
        retire_c   = 1'b1;
        next_state = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cpu_mc_controller.md
Name: cpu_mc_controller

Overview:
Multicycle control unit for the 16-bit, 8-register CPU. Sequences fetch, decode, execute, memory and write-back. Owns the ready/valid handshakes to instruction and data memory and drives every datapath enable. Detects halt (JMP to self), counts retired instructions, and stops the machine on a memory-response timeout.

Parameters:
PC_W, 12, PC / jump-target width; JMP target = instr[PC_W-1:0].
CNT_W, 16, retired-instruction counter width; saturating.
TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before error halt; must be ≥1.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
run  in  1  start request, sampled in IDLE.
instr  in  16  instruction word from instruction memory, valid with imem_ready.
pc  in  PC_W  current PC from datapath.
zero_flag  in  1  ALU zero result from datapath.
imem_req  out  1  instruction fetch request.
imem_ready  in  1  fetch complete; instr valid this cycle.
dmem_req  out  1  data-memory access request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
dmem_ready  in  1  data access complete; load data valid this cycle.
ir_load  out  1  latch instr into the instruction register.
pc_write  out  1  update PC this cycle.
pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
alu_src_imm  out  1  ALU B operand = sign-extended immediate (LW/SW address).
reg_write  out  1  register-file write enable.
wb_sel  out  1  0 = ALU result, 1 = memory data.
halted  out  1  sticky; set by JMP-to-self or timeout.
timeout_err  out  1  sticky; set with halted on watchdog expiry.
illegal_op  out  1  sticky; opcode 8..F decoded.
retired  out  CNT_W  instructions completed, saturating.
state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. fetch_pc, wait counter and retired cleared. Reset mid-access drops imem_req/dmem_req immediately; no completion is counted.
- Outputs are Moore decodes of state, gated by the ready inputs where noted. No output is registered beyond the state.
- IDLE: run=1 → FETCH.
- FETCH: imem_req=1 until imem_ready. On imem_ready, in the same cycle: ir_load=1, pc_write=1, pc_src=00, fetch_pc←pc. Then → DECODE.
- DECODE: dispatch on opcode instr[15:12] held in the IR.
  - 0-3 → EXEC; 4/5 → EXEC; 6 → EXEC.
  - 7 (JMP), target == fetch_pc → HALT, halted=1, retired+1, no pc_write.
  - 7 (JMP), otherwise → pc_write=1, pc_src=10, retired+1, → FETCH.
  - 8-F → illegal_op=1, retired+1, → FETCH (treated as NOP).
- EXEC:
  - ALU ops: alu_op = opcode[1:0] → WB.
  - LW/SW: alu_src_imm=1, alu_op=00 → MEM.
  - BEQ: alu_op=01. If zero_flag=1: pc_write=1, pc_src=01. retired+1 → FETCH.
- MEM: dmem_req=1, dmem_we=(opcode==5), alu_src_imm held. On dmem_ready: LW → WB; SW → retired+1, → FETCH.
- WB: reg_write=1 for one cycle. wb_sel=1 for LW, else 0. retired+1, → FETCH.
- HALT: absorbing. Only rst_n exits it. All strobes 0. run ignored.
- Cycle counts with zero-wait memory (ready in first request cycle):
  - ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - JMP: 2 cycles.
- Watchdog: counter cleared on entry to FETCH/MEM and incremented each cycle the request is pending without ready. When the count reaches TIMEOUT with ready still low, the next state is HALT with timeout_err=1 and halted=1, and the request drops. A ready arriving in the same cycle as expiry wins; no error.
- retired saturates at 2^CNT_W-1.
- Sticky flags clear only on reset.

Decomposition:
- Package cpu_ctrl_pkg: opcode constants OP_ADD..OP_JMP; state encodings IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; pc_src encodings; alu_op encodings.
- One sub-module, ctrl_watchdog (parameter TIMEOUT): inputs clear, pending, ready; output expire. Everything else lives in cpu_mc_controller.

Test Plan:
- Reset, run=1, zero-wait memory, instr 0x0xxx (ADD) → states FETCH, DECODE, EXEC, WB over 4 cycles; reg_write=1 only in cycle 4; retired=1.
- LW with dmem_ready delayed 2 cycles → dmem_req high 3 cycles, dmem_we=0, then wb_sel=1 with reg_write=1; total 7 cycles; retired=1.
- BEQ with zero_flag=1, then with zero_flag=0 → pc_write with pc_src=01 in EXEC only when zero_flag=1; 3 cycles each.
- JMP whose target equals the fetched PC (e.g. fetch at PC=5, instr 0x7005) → halted=1 within 2 cycles; no pc_write in DECODE; retired incremented; HALT held while run toggles.
- imem_ready never asserted with TIMEOUT=15 → imem_req drops after 15 pending cycles; halted=1, timeout_err=1. A repeat run with ready on cycle 15 → no error.
- rst_n pulsed low mid-MEM (dmem_req=1) → imem_req/dmem_req/all outputs 0 immediately; state_dbg=0; retired=0; restart on run works.
